// File: rtl/sar_search_ctrl_if.sv
// Comparator handshake between the SAR search controller (master) and an
// external magnitude comparator (slave).
interface sar_cmp_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] guess;
  logic             guess_valid;
  logic             res_valid;
  logic             res_eq;
  logic             res_gt;
  logic             res_lt;

  modport master (
    output guess,
    output guess_valid,
    input  res_valid,
    input  res_eq,
    input  res_gt,
    input  res_lt
  );

  modport slave (
    input  guess,
    input  guess_valid,
    output res_valid,
    output res_eq,
    output res_gt,
    output res_lt
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives trial guesses into an
// external comparator and resolves the comparator's hidden target bit by bit.
module sar_search_ctrl #(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  sar_cmp_if.master        cmp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [SW-1:0]    steps,
  output logic             err
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRY  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SW-1:0]    steps_q, steps_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             gv_q, gv_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] trial_s;
  logic [2:0]       res_s;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      guess_q  <= '0;
      idx_q    <= '0;
      result_q <= '0;
      steps_q  <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      gv_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      gv_q     <= gv_d;
      done_q   <= done_d;
    end
  end

  // Next-state and search datapath.
  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    idx_d    = idx_q;
    result_d = result_q;
    steps_d  = steps_q;
    err_d    = err_q;
    busy_d   = busy_q;
    gv_d     = gv_q;
    done_d   = 1'b0;
    trial_s  = guess_q;
    res_s    = {cmp.res_eq, cmp.res_gt, cmp.res_lt};

    case (state_q)
      IDLE: begin
        if (start) begin
          guess_d = TOP_BIT;
          idx_d   = IW'(WIDTH - 1);
          steps_d = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          gv_d    = 1'b1;
          state_d = TRY;
        end else begin
          state_d = IDLE;
        end
      end
      TRY: begin
        if (cmp.res_valid) begin
          steps_d = steps_q + SW'(1);
          case (res_s)
            3'b100: begin
              result_d = guess_q;
              state_d  = FIN;
            end
            3'b010, 3'b001: begin
              // gt keeps the trial bit, lt clears it
              trial_s[idx_q] = res_s[1];
              if (idx_q != IW'(0)) begin
                trial_s[idx_q - IW'(1)] = 1'b1;
                idx_d   = idx_q - IW'(1);
                guess_d = trial_s;
              end else begin
                guess_d  = trial_s;
                result_d = trial_s;
                state_d  = FIN;
              end
            end
            default: begin
              err_d    = 1'b1;
              result_d = guess_q;
              state_d  = FIN;
            end
          endcase
          if (state_d == FIN) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            gv_d   = 1'b0;
          end else begin
            done_d = 1'b0;
          end
        end else begin
          state_d = TRY;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        gv_d    = 1'b0;
      end
    endcase
  end

  assign cmp.guess       = guess_q;
  assign cmp.guess_valid = gv_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign result          = result_q;
  assign steps           = steps_q;
  assign err             = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl: comparator model with optional
// latency and fault injection, a behavioural search model, and directed runs.
module tb_sar_search_ctrl;
  localparam int W  = 8;
  localparam int SW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, err;
  logic [W-1:0]  result;
  logic [SW-1:0] steps;

  logic [W-1:0]  target = 8'h00;
  logic [7:0]    lat = 8'd0;
  logic          fault_en = 1'b0;
  logic [7:0]    cmp_wait;
  logic          chk_en = 1'b0;
  int            n_chk = 0;
  int            n_fail = 0;

  sar_cmp_if #(.WIDTH(W)) cmp_if ();

  sar_search_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp    (cmp_if),
    .busy   (busy),
    .done   (done),
    .result (result),
    .steps  (steps),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          active;
    logic          done;
    logic [3:0]    k;
    logic [7:0]    wait_c;
    logic [SW-1:0] steps;
    logic          err;
    logic [W-1:0]  guess;
    logic [W-1:0]  result;
  } model_t;

  model_t m;

  // k-th trial of a binary search: target's bits above the probe, probe bit set
  function automatic logic [W-1:0] trial(input logic [W-1:0] t, input int k);
    int idx;
    logic [15:0] hi;
    idx = W - 1 - k;
    hi  = ({8'h00, t} >> (idx + 1)) << (idx + 1);
    return hi[W-1:0] | W'(1 << idx);
  endfunction

  function automatic model_t step(input model_t c, input logic r, input logic s);
    model_t n;
    n = c;
    if (r) return '0;
    n.done = 1'b0;
    if (c.done) begin
      n.active = 1'b0;
    end else if (!c.active) begin
      if (s) begin
        n.active = 1'b1;
        n.k      = 4'd0;
        n.wait_c = 8'd0;
        n.steps  = '0;
        n.err    = 1'b0;
        n.guess  = trial(target, 0);
      end
    end else if (c.wait_c != lat) begin
      n.wait_c = c.wait_c + 8'd1;
    end else begin
      n.steps  = c.steps + SW'(1);
      n.wait_c = 8'd0;
      if (fault_en && c.steps == SW'(1)) begin
        n.err = 1'b1; n.result = c.guess; n.active = 1'b0; n.done = 1'b1;
      end else if (c.guess == target) begin
        n.result = target; n.active = 1'b0; n.done = 1'b1;
      end else if (c.k == 4'(W - 1)) begin
        n.guess = target; n.result = target; n.active = 1'b0; n.done = 1'b1;
      end else begin
        n.k     = c.k + 4'd1;
        n.guess = trial(target, int'(c.k) + 1);
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= step(m, rst, start);

  // Comparator: result lines always driven, valid after lat waiting cycles
  always @(posedge clk) begin
    if (!cmp_if.guess_valid || cmp_if.res_valid) cmp_wait <= 8'd0;
    else cmp_wait <= cmp_wait + 8'd1;
  end
  assign cmp_if.res_valid = cmp_if.guess_valid && (cmp_wait == lat);
  always_comb begin
    cmp_if.res_eq = (target == cmp_if.guess);
    cmp_if.res_gt = (target >  cmp_if.guess);
    cmp_if.res_lt = (target <  cmp_if.guess);
    if (fault_en && m.steps == SW'(1)) begin
      cmp_if.res_eq = 1'b0;
      cmp_if.res_gt = 1'b1;
      cmp_if.res_lt = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the behavioural model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("guess",       32'(cmp_if.guess),       32'(m.guess));
      chk("guess_valid", 32'(cmp_if.guess_valid), 32'(m.active));
      chk("busy",        32'(busy),               32'(m.active));
      chk("done",        32'(done),               32'(m.done));
      chk("result",      32'(result),             32'(m.result));
      chk("steps",       32'(steps),              32'(m.steps));
      chk("err",         32'(err),                32'(m.err));
    end
  end

  task automatic search(input logic [W-1:0] t, input logic [7:0] l, input logic flt,
                        input int mid_start, output int cyc);
    target   = t;
    lat      = l;
    fault_en = flt;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 400) begin
      start = (cyc == mid_start);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 400) chk("done_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic expect_end(input string tag, input int cyc, input int e_cyc,
                            input logic [W-1:0] e_res, input int e_steps, input logic e_err);
    chk({tag, "_cycles"}, 32'(cyc),    32'(e_cyc));
    chk({tag, "_result"}, 32'(result), 32'(e_res));
    chk({tag, "_steps"},  32'(steps),  32'(e_steps));
    chk({tag, "_err"},    32'(err),    32'(e_err));
  endtask

  task automatic expect_zero(input string tag);
    chk({tag, "_guess"}, 32'(cmp_if.guess),       32'd0);
    chk({tag, "_gv"},    32'(cmp_if.guess_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),               32'd0);
    chk({tag, "_done"},  32'(done),               32'd0);
    chk({tag, "_res"},   32'(result),             32'd0);
    chk({tag, "_steps"}, 32'(steps),              32'd0);
    chk({tag, "_err"},   32'(err),                32'd0);
  endtask

  initial begin
    int cyc;
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    expect_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    search(8'h80, 8'd0, 1'b0, 0, cyc);  expect_end("t80", cyc, 2, 8'h80, 1, 1'b0);
    @(negedge clk);
    search(8'h5A, 8'd0, 1'b0, 0, cyc);  expect_end("t5a", cyc, 8, 8'h5A, 7, 1'b0);
    @(negedge clk);
    search(8'h00, 8'd0, 1'b0, 0, cyc);  expect_end("t00", cyc, 9, 8'h00, 8, 1'b0);
    @(negedge clk);
    search(8'hFF, 8'd0, 1'b0, 0, cyc);  expect_end("tff", cyc, 9, 8'hFF, 8, 1'b0);
    @(negedge clk);
    search(8'h37, 8'd3, 1'b0, 6, cyc);  expect_end("lat3", cyc, 33, 8'h37, 8, 1'b0);
    @(negedge clk);
    search(8'h5A, 8'd0, 1'b1, 0, cyc);  expect_end("fault", cyc, 3, 8'h40, 2, 1'b1);
    fault_en = 1'b0;
    @(negedge clk);
    search(8'h5A, 8'd0, 1'b0, 0, cyc);  expect_end("clr", cyc, 8, 8'h5A, 7, 1'b0);
    @(negedge clk);

    // Reset during the third TRY cycle
    target = 8'h5A;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_zero("midrst");
    search(8'h5A, 8'd0, 1'b0, 0, cyc);  expect_end("after_rst", cyc, 8, 8'h5A, 7, 1'b0);
    @(negedge clk);

    // start and rst together: reset takes precedence
    start = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    expect_zero("start_rst");
    @(negedge clk);
    chk("still_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
